down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer_pkg.sv | 4 +
 rtl/down_timer.sv | 73 +++++++
 tb/tb_down_timer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared state encoding for the down_timer block
package down_timer_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with pause, abort, optional auto-reload and registered terminal-count pulse
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_auto,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);
    state_t state, state_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx, count_nx;
    logic auto_reg, auto_nx, tc_nx;

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        reload_nx = reload_reg;
        auto_nx   = auto_reg;
        tc_nx     = 1'b0;
        if (state == IDLE) begin
            if (load_valid) begin
                count_nx  = load_value;
                reload_nx = load_value;
                auto_nx   = load_auto;
                state_nx  = (load_value != '0) ? RUN : IDLE;
                tc_nx     = (load_value == '0);
            end
        end else if (abort) begin
            state_nx = IDLE;
            count_nx = '0;
        end else if (enable) begin
            if (count == WIDTH'(1)) begin
                tc_nx    = 1'b1;
                count_nx = auto_reg ? reload_reg : '0;
                state_nx = auto_reg ? RUN : IDLE;
            end else begin
                count_nx = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            reload_reg <= '0;
            auto_reg   <= 1'b0;
            tc         <= 1'b0;
        end else begin
            count      <= count_nx;
            reload_reg <= reload_nx;
            auto_reg   <= auto_nx;
            tc         <= tc_nx;
        end
    end

    always_comb begin
        busy       = (state == RUN);
        load_ready = (state == IDLE);
    end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: randomized and directed checks of down_timer against a behavioural model
module tb_down_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_valid = 1'b0;
    logic load_ready;
    logic [7:0] load_value = '0;
    logic load_auto = 1'b0;
    logic enable = 1'b0;
    logic abort = 1'b0;
    logic [7:0] count;
    logic busy, tc;

    int checks = 0;
    int errors = 0;

    down_timer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_value(load_value), .load_auto(load_auto), .enable(enable), .abort(abort),
        .count(count), .busy(busy), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining count, running flag and pending terminal pulse
    int m_count = 0, m_reload = 0;
    bit m_run = 0, m_auto = 0, m_tc = 0, m_on = 0;

    always @(posedge clk) begin
        m_tc = 0;
        if (reset) begin
            m_count = 0; m_reload = 0; m_auto = 0; m_run = 0; m_on = 1;
        end else if (!m_run) begin
            if (load_valid) begin
                m_count = load_value; m_reload = load_value; m_auto = load_auto;
                m_run = (load_value != 0);
                m_tc = (load_value == 0);
            end
        end else if (abort) begin
            m_count = 0; m_run = 0;
        end else if (enable) begin
            if (m_count == 1) begin
                m_tc = 1;
                m_count = m_auto ? m_reload : 0;
                m_run = m_auto;
            end else begin
                m_count = m_count - 1;
            end
        end
        #2;
        if (m_on) begin
            chk("model_count", count, m_count);
            chk("model_tc", tc, m_tc);
            chk("model_busy", busy, m_run);
            chk("model_ready", load_ready, !m_run);
        end
    end

    task automatic cyc(input logic lv, input logic [7:0] v, input logic la,
                       input logic en, input logic ab, input logic rs);
        load_valid = lv; load_value = v; load_auto = la; enable = en; abort = ab; reset = rs;
        @(posedge clk);
        #3;
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 1);

        cyc(1, 5, 0, 1, 0, 0);
        chk("l5_count", count, 5);
        chk("l5_busy", busy, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("l5_seq", count, 5 - i);
            chk("l5_tc", tc, i == 5);
        end
        chk("l5_busy_end", busy, 0);
        chk("l5_ready_end", load_ready, 1);

        cyc(1, 3, 1, 1, 0, 0);
        chk("a3_count", count, 3);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("a3_seq", count, 3 - (i % 3));
            chk("a3_tc", tc, (i % 3) == 0);
            chk("a3_busy", busy, 1);
        end
        cyc(0, 0, 0, 1, 1, 0);
        chk("a3_abort", count, 0);

        cyc(1, 4, 0, 0, 0, 0);
        begin
            bit en_pat[6] = '{1, 0, 0, 1, 1, 1};
            int exp_c[6] = '{3, 3, 3, 2, 1, 0};
            for (int i = 0; i < 6; i++) begin
                cyc(0, 0, 0, en_pat[i], 0, 0);
                chk("p4_seq", count, exp_c[i]);
                chk("p4_tc", tc, i == 5);
            end
        end

        cyc(1, 10, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 99, 1, 1, 0, 0);
        chk("b10_count6", count, 6);
        cyc(1, 99, 0, 1, 1, 0);
        chk("b10_abort_count", count, 0);
        chk("b10_abort_busy", busy, 0);
        chk("b10_abort_tc", tc, 0);

        cyc(1, 0, 0, 0, 0, 0);
        chk("z_tc", tc, 1);
        chk("z_busy", busy, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("z_tc_off", tc, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("one_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("one_tc", tc, 1);
            chk("one_count_hold", count, 1);
        end
        cyc(0, 0, 0, 0, 1, 0);

        cyc(1, 200, 0, 1, 0, 0);
        run_en(50);
        chk("r200_count", count, 150);
        cyc(0, 0, 0, 1, 0, 1);
        chk("r200_rst_count", count, 0);
        chk("r200_rst_tc", tc, 0);
        chk("r200_rst_ready", load_ready, 1);

        cyc(1, 255, 0, 1, 0, 0);
        run_en(254);
        chk("f255_count1", count, 1);
        chk("f255_early_tc", tc, 0);
        run_en(1);
        chk("f255_tc", tc, 1);
        chk("f255_count0", count, 0);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) == 0,
                8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 4)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
